// File: rtl/mem_arbiter.sv
// Three-port arbiter in front of a single-port synchronous RAM with one-cycle read latency.
// The debug port has fixed priority. Fetch and data ports share the RAM round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nx;
    logic [2:0]        gnt, gnt_q;          // {dbg, d, if}
    logic              last_d, last_d_nx;   // 1: data port won the last if/d grant
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] data_q, sel_data;
    logic              sel_we;

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        last_d_nx = last_d;
        sel_addr  = addr_q;
        sel_data  = data_q;
        sel_we    = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_req) begin
                    gnt      = 3'b100;
                    sel_addr = dbg_addr;
                    sel_data = dbg_wdata;
                    sel_we   = dbg_we;
                end else if (if_req && (!d_req || last_d)) begin
                    gnt       = 3'b001;
                    sel_addr  = if_addr;
                    last_d_nx = 1'b0;
                end else if (d_req) begin
                    gnt       = 3'b010;
                    sel_addr  = d_addr;
                    sel_data  = d_wdata;
                    sel_we    = d_we;
                    last_d_nx = 1'b1;
                end
                if (gnt != 3'b000) state_nx = WAIT;
            end
            WAIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            last_d <= 1'b1;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            gnt_q  <= gnt;
            last_d <= last_d_nx;
            addr_q <= sel_addr;
            data_q <= sel_data;
        end
    end

    // RAM controls are combinational from the selected port, so reset must gate them directly.
    assign ram_wren    = sel_we & ~rst;
    assign ram_address = rst ? '0 : sel_addr;
    assign ram_data    = rst ? '0 : sel_data;

    assign if_ack    = (state == WAIT) & gnt_q[0];
    assign d_ack     = (state == WAIT) & gnt_q[1];
    assign dbg_ack   = (state == WAIT) & gnt_q[2];
    assign if_rdata  = ram_q;
    assign d_rdata   = ram_q;
    assign dbg_rdata = ram_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the arbitration rules and memory contents.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0, dbg_addr = '0;
    logic [DW-1:0] d_wdata = '0, dbg_wdata = '0;
    logic          if_ack, d_ack, dbg_ack, ram_wren;
    logic [DW-1:0] if_rdata, d_rdata, dbg_rdata, ram_data, ram_q;
    logic [AW-1:0] ram_address;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return (i == 5) ? 32'h0000_0008 : 32'(i) * 32'h0101_0101 + 32'h10;
    endfunction

    // Synchronous single-port RAM: registered address, one-cycle read latency.
    logic          preload = 1'b0;
    logic [DW-1:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
        end else if (ram_wren) begin
            ram_mem[ram_address] <= ram_data;
        end
        ram_q <= ram_mem[ram_address];
    end

    int compared = 0;
    int mismatched = 0;

    // Transaction-level reference state
    logic [DW-1:0] mm [0:255];
    bit            m_busy, m_wbusy, m_last_if, m_wr;
    int            m_port;
    logic [DW-1:0] m_rd, m_data;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_acked;
    int            n_ack [3];
    int            n_wren;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wbusy = 0; m_last_if = 0; m_addr = '0; m_data = '0; m_acked = '0;
    endtask

    task automatic clr_counts();
        n_ack[0] = 0; n_ack[1] = 0; n_ack[2] = 0; n_wren = 0;
    endtask

    // One clock cycle: entered just after a rising edge, checks at the falling edge.
    task automatic tick();
        int         issue;
        logic [2:0] ea;
        @(negedge clk);
        issue = -1;
        ea    = '0;
        if (m_busy)                  ea[m_port] = 1'b1;
        else if (dbg_req)            issue = 2;
        else if (if_req && d_req)    issue = m_last_if ? 1 : 0;
        else if (if_req)             issue = 0;
        else if (d_req)              issue = 1;
        m_wr = 0;
        case (issue)
            0: m_addr = if_addr;
            1: begin m_addr = d_addr;   m_data = d_wdata;   m_wr = d_we;   end
            2: begin m_addr = dbg_addr; m_data = dbg_wdata; m_wr = dbg_we; end
            default: ;
        endcase
        chk("acks", {29'd0, dbg_ack, d_ack, if_ack}, {29'd0, ea});
        chk("ram_wren", {31'd0, ram_wren}, {31'd0, m_wr});
        chk("ram_address", {24'd0, ram_address}, {24'd0, m_addr});
        if (m_wr) chk("ram_data", ram_data, m_data);
        if (m_busy && !m_wbusy) begin
            case (m_port)
                0: chk("if_rdata", if_rdata, m_rd);
                1: chk("d_rdata", d_rdata, m_rd);
                default: chk("dbg_rdata", dbg_rdata, m_rd);
            endcase
        end
        n_ack[0] += int'(if_ack); n_ack[1] += int'(d_ack); n_ack[2] += int'(dbg_ack);
        n_wren += int'(ram_wren);
        if (m_busy) begin
            m_busy = 0;
        end else if (issue >= 0) begin
            m_busy  = 1;
            m_port  = issue;
            m_wbusy = m_wr;
            if (m_wr) mm[m_addr] = m_data;
            else      m_rd = mm[m_addr];
            if (issue < 2) m_last_if = (issue == 0);
        end
        m_acked = ea;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = init_val(i);
        model_reset();
        clr_counts();
        preload = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        // Reset forces RAM controls even with a request present
        if_req = 1'b1; if_addr = 8'h05;
        #1;
        chk("rst_acks", {29'd0, dbg_ack, d_ack, if_ack}, 32'd0);
        chk("rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("rst_addr", {24'd0, ram_address}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Fetch of RAM[5]
        tick();
        chk("fetch_ack", {31'd0, if_ack}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h0000_0008);
        tick();
        if_req = 1'b0;

        // Data write then read-back
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_ack", {31'd0, d_ack}, 32'd1);
        tick();
        d_we = 1'b0;
        tick();
        chk("rd_ack", {31'd0, d_ack}, 32'd1);
        chk("rd_data", d_rdata, 32'hDEAD_BEEF);
        tick();
        d_req = 1'b0;

        // Contention after reset: if, d, if, d
        rst = 1'b1; model_reset(); @(posedge clk); #1 rst = 1'b0;
        if_req = 1'b1; if_addr = 8'h03;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h04;
        clr_counts();
        repeat (8) tick();
        chk("rr_if_acks", 32'(n_ack[0]), 32'd2);
        chk("rr_d_acks", 32'(n_ack[1]), 32'd2);

        // Debug starves the others, then round-robin resumes
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h07;
        clr_counts();
        repeat (6) tick();
        chk("dbg_acks", 32'(n_ack[2]), 32'd3);
        chk("starved_acks", 32'(n_ack[0] + n_ack[1]), 32'd0);
        dbg_req = 1'b0;
        clr_counts();
        repeat (4) tick();
        chk("resume_if", 32'(n_ack[0]), 32'd1);
        chk("resume_d", 32'(n_ack[1]), 32'd1);
        if_req = 1'b0; d_req = 1'b0;

        // Reset during the result cycle of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h09;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_wait_addr", {24'd0, ram_address}, 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        clr_counts();
        tick();
        tick();
        chk("reissue_ack", 32'(n_ack[1]), 32'd1);
        d_req = 1'b0;

        // Reset during an issue-cycle write drops ram_wren and loses the write
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h09; d_wdata = 32'h1234_5678;
        #1;
        chk("issue_wren", {31'd0, ram_wren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_issue_wren", {31'd0, ram_wren}, 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        d_we = 1'b0;
        tick();
        tick();
        d_req = 1'b0;

        // Fetch stream with one concurrent data write
        if_req = 1'b1; if_addr = 8'h02;
        clr_counts();
        tick();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h0B; d_wdata = 32'hABCD_0123;
        tick();
        tick();
        d_req = 1'b0; d_we = 1'b0;
        tick();
        tick();
        chk("wren_cycles", 32'(n_wren), 32'd1);
        if_req = 1'b0;

        // Random traffic, each requester holding its request until acked
        m_acked = '0;
        repeat (400) begin
            if (m_acked[0]) if_req = 1'b0;
            if (m_acked[1]) d_req = 1'b0;
            if (m_acked[2]) dbg_req = 1'b0;
            if (!if_req && $urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = AW'($urandom_range(31));
            end
            if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1));
                d_addr = AW'($urandom_range(31)); d_wdata = $urandom;
            end
            if (!dbg_req && $urandom_range(7) == 0) begin
                dbg_req = 1'b1; dbg_we = 1'($urandom_range(1));
                dbg_addr = AW'($urandom_range(31)); dbg_wdata = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
